// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the keypad scanner and its event FIFO.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        COMPARE,
        EMIT
    } scan_state_t;

    // Wide enough for the largest 8x8 matrix; users slice down to KEY_W.
    localparam int CODE_W_MAX = 8;

    typedef struct packed {
        logic                  key_release;
        logic [CODE_W_MAX-1:0] code;
    } key_event_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Register width for a counter/index over n values, never zero.
    function automatic int width_of(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event FIFO; head data reads as zero while empty.
module key_event_fifo
    import keypad_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic             full
);

    localparam int AW = width_of(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign valid     = (count_reg != '0);
    assign full      = (count_reg == (AW + 1)'(DEPTH));
    assign do_pop    = pop && valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push   = push && (!full || do_pop);
    assign head_data = valid ? mem[rd_ptr_reg] : '0;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (do_push && !do_pop)
                count_reg <= count_reg + (AW + 1)'(1);
            else if (do_pop && !do_push)
                count_reg <= count_reg - (AW + 1)'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning matrix keypad reader with frame debounce and a press/release event FIFO.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int CLK_DIV    = 50000,
    parameter  int DEBOUNCE   = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int NKEYS      = ROWS * COLS,
    localparam int KEY_W      = clog2(NKEYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  column,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [KEY_W-1:0] key_code,
    output logic             key_release,
    output logic             multi_key
);

    localparam int CW = width_of(COLS);
    localparam int TW = width_of(CLK_DIV);

    scan_state_t      state_reg;
    logic [ROWS-1:0]  row_meta_reg;
    logic [ROWS-1:0]  row_sync_reg;
    logic [ROWS-1:0]  rows_n;
    logic [TW-1:0]    tick_cnt_reg;
    logic             tick;
    logic [CW-1:0]    col_idx_reg;
    logic [3:0]       stable_cnt_reg;
    logic [3:0]       stable_cnt_next;
    logic [NKEYS-1:0] frame_reg;
    logic [NKEYS-1:0] prev_frame_reg;
    logic [NKEYS-1:0] debounced_reg;
    logic [NKEYS-1:0] debounced_minus_one;
    logic [NKEYS-1:0] frame_sampled;
    logic [KEY_W-1:0] k_reg;
    logic [COLS-1:0]  column_reg;
    logic             multi_key_reg;
    logic             emit_diff;
    logic             fifo_full;
    logic             fifo_push;
    logic             fifo_pop;
    key_event_t       push_event;
    key_event_t       head_event;
    logic             unused_code_bits;

    assign rows_n = ~row_sync_reg;
    assign tick   = (tick_cnt_reg == TW'(CLK_DIV - 1));

    // Only the keys in the currently driven column take the sampled row value.
    generate
        for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
            assign frame_sampled[gi] = (col_idx_reg == CW'(gi % COLS)) ? rows_n[gi / COLS]
                                                                        : frame_reg[gi];
        end
    endgenerate

    always_comb begin
        stable_cnt_next = 4'd1;
        if (frame_reg == prev_frame_reg)
            stable_cnt_next = (stable_cnt_reg >= 4'(DEBOUNCE)) ? 4'(DEBOUNCE)
                                                                : stable_cnt_reg + 4'd1;
    end

    assign emit_diff  = (frame_reg[k_reg] != debounced_reg[k_reg]);
    assign fifo_pop   = key_valid && key_ready;
    assign fifo_push  = (state_reg == EMIT) && emit_diff && (!fifo_full || fifo_pop);
    assign push_event = '{key_release: ~frame_reg[k_reg], code: CODE_W_MAX'(k_reg)};

    // x & (x-1) is non-zero exactly when two or more bits are set.
    assign debounced_minus_one = debounced_reg - NKEYS'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= SCAN;
            row_meta_reg   <= '1;
            row_sync_reg   <= '1;
            tick_cnt_reg   <= '0;
            col_idx_reg    <= '0;
            stable_cnt_reg <= '0;
            frame_reg      <= '0;
            prev_frame_reg <= '0;
            debounced_reg  <= '0;
            k_reg          <= '0;
            column_reg     <= ~(COLS'(1));
            multi_key_reg  <= 1'b0;
        end else begin
            row_meta_reg  <= row;
            row_sync_reg  <= row_meta_reg;
            multi_key_reg <= |(debounced_reg & debounced_minus_one);
            case (state_reg)
                SCAN: begin
                    if (tick) begin
                        tick_cnt_reg <= '0;
                        frame_reg    <= frame_sampled;
                        if (col_idx_reg == CW'(COLS - 1)) begin
                            state_reg  <= COMPARE;
                            column_reg <= '1;
                        end else begin
                            col_idx_reg <= col_idx_reg + CW'(1);
                            column_reg  <= ~(COLS'(1) << (col_idx_reg + CW'(1)));
                        end
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + TW'(1);
                    end
                end
                COMPARE: begin
                    stable_cnt_reg <= stable_cnt_next;
                    if (frame_reg != prev_frame_reg) prev_frame_reg <= frame_reg;
                    if (stable_cnt_next == 4'(DEBOUNCE) && frame_reg != debounced_reg) begin
                        state_reg <= EMIT;
                        k_reg     <= '0;
                    end else begin
                        state_reg    <= SCAN;
                        col_idx_reg  <= '0;
                        tick_cnt_reg <= '0;
                        column_reg   <= ~(COLS'(1));
                    end
                end
                EMIT: begin
                    // Hold on a changed key until the FIFO can take its event.
                    if (!emit_diff || fifo_push) begin
                        if (emit_diff) debounced_reg[k_reg] <= frame_reg[k_reg];
                        if (k_reg == KEY_W'(NKEYS - 1)) begin
                            state_reg    <= SCAN;
                            col_idx_reg  <= '0;
                            tick_cnt_reg <= '0;
                            column_reg   <= ~(COLS'(1));
                        end else begin
                            k_reg <= k_reg + KEY_W'(1);
                        end
                    end
                end
                default: state_reg <= SCAN;
            endcase
        end
    end

    key_event_fifo #(
        .WIDTH ($bits(key_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_event),
        .pop       (fifo_pop),
        .head_data (head_event),
        .valid     (key_valid),
        .full      (fifo_full)
    );

    assign column           = column_reg;
    assign multi_key        = multi_key_reg;
    assign key_code         = head_event.code[KEY_W-1:0];
    assign key_release      = head_event.key_release;
    assign unused_code_bits = |head_event.code[CODE_W_MAX-1:KEY_W];

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows, a monitor checks popped events.
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int CLK_DIV    = 4;
    localparam int DEBOUNCE   = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME      = COLS * CLK_DIV + 1;
    localparam logic [15:0] MULTI = 16'h8229;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_ready = 1'b1;
    logic [3:0]  row;
    logic [3:0]  column;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_release;
    logic        multi_key;
    logic [15:0] pressed = '0;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          valid_cycles = 0;
    bit          multi_seen = 1'b0;
    logic [4:0]  expq[$];
    int          pop_cycles[$];

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .row(row), .column(column), .key_valid(key_valid),
        .key_ready(key_ready), .key_code(key_code), .key_release(key_release), .multi_key(multi_key)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Keypad matrix: a row reads low when a pressed key sits in a driven (low) column.
    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !column[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int min);
        checks++;
        if (act < min) begin
            errors++;
            $display("FAIL %s: got %0d, required at least %0d", name, act, min);
        end
    endtask

    task automatic expect_keys(input logic [15:0] keys, input logic rel);
        for (int k = 0; k < 16; k++)
            if (keys[k]) expq.push_back({rel, 4'(k)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((expq.size() != 0 || key_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expq.size() != 0 || key_valid) begin
            errors++;
            $display("FAIL %s: %0d events still pending after %0d cycles, required 0", name, expq.size(), n);
        end
    endtask

    // Monitor: every accepted event is compared against the scoreboard head.
    initial begin
        logic [4:0] exp_ev;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (multi_key) multi_seen = 1'b1;
                if (key_valid) valid_cycles++;
                if (key_valid && key_ready) begin
                    pop_cycles.push_back(cyc);
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL event_unexpected: got code=%0d release=%0d, required no event",
                                 key_code, key_release);
                    end else begin
                        exp_ev = expq.pop_front();
                        if ({key_release, key_code} !== exp_ev) begin
                            errors++;
                            $display("FAIL event: got code=%0d release=%0d, required code=%0d release=%0d",
                                     key_code, key_release, exp_ev[3:0], exp_ev[4]);
                        end else begin
                            $display("event cycle=%0d code=%0d release=%0d", cyc, key_code, key_release);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0] e;
        int         t0;
        int         rst_cyc;
        int         v0;

        // Reset state and idle column sequence
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("reset_key_valid", key_valid, 0);
                check("reset_key_code", key_code, 0);
                check("reset_key_release", key_release, 0);
                check("reset_multi_key", multi_key, 0);
            end
            e = ((i % FRAME) == FRAME - 1) ? 4'b1111 : ~(4'b0001 << ((i % FRAME) / CLK_DIV));
            check($sformatf("idle_column[%0d]", i), column, e);
        end

        // Single press and release of row1/col2
        multi_seen = 1'b0;
        v0 = valid_cycles;
        step();
        pressed[6] = 1'b1;
        expect_keys(16'h0040, 1'b0);
        wait_drain("press6", 300);
        repeat (2 * FRAME) @(negedge clk);
        check("press6_valid_cycles", valid_cycles - v0, 1);
        step();
        pressed[6] = 1'b0;
        expect_keys(16'h0040, 1'b1);
        wait_drain("release6", 300);
        repeat (2 * FRAME) @(negedge clk);
        check("single_key_multi_seen", multi_seen, 0);

        // Bouncing key, then stable press
        for (int i = 0; i < 6; i++) begin
            step();
            pressed[6] = (i % 2 == 0);
            repeat (FRAME - 1) @(posedge clk);
        end
        step();
        pressed[6] = 1'b1;
        t0 = cyc;
        pop_cycles.delete();
        expect_keys(16'h0040, 1'b0);
        wait_drain("bounce_press", 300);
        check("bounce_event_count", pop_cycles.size(), 1);
        check_ge("bounce_latency", (pop_cycles.size() > 0) ? pop_cycles[0] - t0 : 0, 2 * FRAME + 6);
        step();
        pressed[6] = 1'b0;
        expect_keys(16'h0040, 1'b1);
        wait_drain("bounce_release", 300);

        // Five keys with back-pressure: FIFO fills, EMIT stalls on the fifth
        step();
        key_ready = 1'b0;
        pressed = MULTI;
        expect_keys(MULTI, 1'b0);
        repeat (6 * FRAME) @(negedge clk);
        check("stall_column", column, 4'b1111);
        check("stall_key_valid", key_valid, 1);
        check("stall_head_code", key_code, 0);
        check("stall_head_release", key_release, 0);
        check("stall_multi_key", multi_key, 1);
        step();
        key_ready = 1'b1;
        wait_drain("multi_press", 300);
        step();
        pressed = '0;
        expect_keys(MULTI, 1'b1);
        wait_drain("multi_release", 300);
        repeat (2 * FRAME) @(negedge clk);
        check("released_multi_key", multi_key, 0);

        // Reset during the stall discards pending events; held keys re-debounce
        step();
        key_ready = 1'b0;
        pressed = MULTI;
        repeat (6 * FRAME) @(negedge clk);
        check("stall2_column", column, 4'b1111);
        check("stall2_key_valid", key_valid, 1);
        step();
        reset = 1'b1;
        rst_cyc = cyc + 1;
        step();
        reset = 1'b0;
        key_ready = 1'b1;
        pop_cycles.delete();
        expect_keys(MULTI, 1'b0);
        @(negedge clk);
        check("post_reset_key_valid", key_valid, 0);
        check("post_reset_column", column, 4'b1110);
        check("post_reset_multi_key", multi_key, 0);
        wait_drain("reset_presses", 400);
        check("reset_event_count", pop_cycles.size(), 5);
        check_ge("reset_latency", (pop_cycles.size() > 0) ? pop_cycles[0] - rst_cyc : 0, 3 * FRAME - 3);
        step();
        pressed = '0;
        expect_keys(MULTI, 1'b1);
        wait_drain("reset_releases", 300);
        repeat (2 * FRAME) @(negedge clk);
        check("final_key_valid", key_valid, 0);
        check("final_queue_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
